// File: rtl/qspi_flash_pkg.sv
// Shared constants for the QSPI quad-output fast-read sequencer.
package qspi_flash_pkg;

  // Sequencer states, kept as plain constants so the encoding stays fixed.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_CMD      = 3'd1;
  localparam state_t ST_ADDR     = 3'd2;
  localparam state_t ST_DUMMY    = 3'd3;
  localparam state_t ST_DATA     = 3'd4;
  localparam state_t ST_DESELECT = 3'd5;

  // Common SPI NOR read opcodes: fast read (x1 data) and quad-output fast read.
  localparam logic [7:0] OPC_FAST_READ      = 8'h0B;
  localparam logic [7:0] OPC_QUAD_OUT_READ  = 8'h6B;

  // Byte shifted out during dummy cycles.
  localparam logic [7:0] DUMMY_FILL = 8'h00;

endpackage

// File: rtl/qspi_flash_read_sequencer.sv
// Drives a QSPI transceiver through opcode / address / dummy (x1) and data (x4)
// phases of a SPI NOR fast read, owns flash chip select, and streams received
// bytes back to a simple read-request client.
module qspi_flash_read_sequencer
  import qspi_flash_pkg::*;
#(
  parameter logic [7:0] READ_OPCODE    = OPC_QUAD_OUT_READ,
  parameter int         ADDR_BYTES     = 3,
  parameter int         DUMMY_BYTES    = 1,
  parameter int         CS_HIGH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic [31:0] rd_addr,
  input  logic [15:0] rd_len,
  output logic        busy,
  output logic        rd_data_valid,
  output logic [7:0]  rd_data,
  output logic        rd_done,
  output logic        flash_cs_n,
  output logic        shift_en,
  output logic        quad_shift_en,
  output logic [7:0]  tx_data,
  output logic        auto_restart,
  input  logic        shift_done,
  input  logic [7:0]  rx_data
);

  localparam logic [7:0]  ADDR_N  = 8'(ADDR_BYTES);
  localparam logic [7:0]  DUMMY_N = 8'(DUMMY_BYTES);
  localparam logic [15:0] CS_LOAD = 16'(CS_HIGH_CYCLES);

  state_t      state;
  logic [7:0]  byte_cnt;   // x1 bytes already started in the current phase
  logic [15:0] remaining;  // data bytes not yet received, including the one in flight
  logic [15:0] cs_cnt;     // deselect hold countdown
  logic [31:0] addr_q;

  // Address byte idx (0 = most significant of the ADDR_BYTES used).
  function automatic logic [7:0] addr_byte(input logic [31:0] a, input logic [7:0] idx);
    int sh;
    sh = 8 * (ADDR_BYTES - 1 - int'(idx));
    return 8'(a >> sh);
  endfunction

  // Read FSM: every transceiver strobe is issued the cycle after the previous
  // byte's shift_done, so nothing is ever started while a byte is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      byte_cnt      <= '0;
      remaining     <= '0;
      cs_cnt        <= '0;
      addr_q        <= '0;
      busy          <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
      rd_done       <= 1'b0;
      flash_cs_n    <= 1'b1;
      shift_en      <= 1'b0;
      quad_shift_en <= 1'b0;
      tx_data       <= '0;
      auto_restart  <= 1'b0;
    end else begin
      shift_en      <= 1'b0;
      quad_shift_en <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rd_en) begin
            addr_q    <= rd_addr;
            remaining <= rd_len;
            if (rd_len != 16'd0) begin
              state      <= ST_CMD;
              flash_cs_n <= 1'b0;
              busy       <= 1'b1;
              shift_en   <= 1'b1;
              tx_data    <= READ_OPCODE;
            end else begin
              // Zero-length request completes without touching the flash.
              rd_done <= 1'b1;
            end
          end
        end
        ST_CMD: begin
          if (shift_done) begin
            state    <= ST_ADDR;
            byte_cnt <= 8'd1;
            shift_en <= 1'b1;
            tx_data  <= addr_byte(addr_q, 8'd0);
          end
        end
        ST_ADDR: begin
          if (shift_done) begin
            if (byte_cnt != ADDR_N) begin
              byte_cnt <= byte_cnt + 8'd1;
              shift_en <= 1'b1;
              tx_data  <= addr_byte(addr_q, byte_cnt);
            end else if (DUMMY_N != 8'd0) begin
              state    <= ST_DUMMY;
              byte_cnt <= 8'd1;
              shift_en <= 1'b1;
              tx_data  <= DUMMY_FILL;
            end else begin
              state         <= ST_DATA;
              byte_cnt      <= '0;
              quad_shift_en <= 1'b1;
              auto_restart  <= (remaining > 16'd1);
            end
          end
        end
        ST_DUMMY: begin
          if (shift_done) begin
            if (byte_cnt != DUMMY_N) begin
              byte_cnt <= byte_cnt + 8'd1;
              shift_en <= 1'b1;
              tx_data  <= DUMMY_FILL;
            end else begin
              state         <= ST_DATA;
              byte_cnt      <= '0;
              quad_shift_en <= 1'b1;
              auto_restart  <= (remaining > 16'd1);
            end
          end
        end
        ST_DATA: begin
          // One quad strobe starts the burst; auto_restart keeps it going.
          if (shift_done) begin
            rd_data       <= rx_data;
            rd_data_valid <= 1'b1;
            remaining     <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              state        <= ST_DESELECT;
              flash_cs_n   <= 1'b1;
              auto_restart <= 1'b0;
              cs_cnt       <= CS_LOAD;
            end else begin
              // Continue only if another byte follows the one now in flight.
              auto_restart <= (remaining > 16'd2);
            end
          end
        end
        ST_DESELECT: begin
          if (cs_cnt <= 16'd1) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            rd_done <= 1'b1;
            cs_cnt  <= '0;
          end else begin
            cs_cnt <= cs_cnt - 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
